// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle signed divider.
package div_pkg;
  localparam int DIV_WIDTH   = 32;
  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = 34;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CORR,
    SIGN
  } state_t;
endpackage

// File: rtl/div_32_add_32.sv
// Fixed-width 32-bit adder with carry-in/carry-out; the divider's single arithmetic element.
module add_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};
endmodule

// File: rtl/div_32.sv
// Signed 32-bit non-restoring divider, one quotient bit per clock through a shared add_32.
module div_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output state_t           dbg_state
);
  // Handshake: start is accepted on any rising edge where busy=0; operands are
  // captured on that edge. busy stays high until the edge that raises done for
  // one cycle; q/r/div_by_zero are valid from that cycle and hold until the next done.

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] a_q, a_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] m_q, m_d;
  logic        m_neg_q, m_neg_d;
  logic [31:0] nm_q, nm_d;
  logic        off_q, off_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dbz_out_q, dbz_out_d;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [32:0] a_sh;
  logic        iter_inv, iter_b32, iter_a32;

  // The divisor is kept raw; a negative divisor flips add/subtract so the
  // adder always works on |divisor| without a separate negation.
  assign a_sh     = {a_q[31:0], quo_q[31]};
  assign iter_inv = ~a_q[32] ^ m_neg_q;
  assign iter_b32 = iter_inv ? ~m_q[31] : m_q[31];
  assign iter_a32 = a_sh[32] ^ iter_b32 ^ add_cout;

  add_32 u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        add_a   = ~dividend;
        add_cin = 1'b1;
      end
      ITER: begin
        add_a   = a_sh[31:0];
        add_b   = iter_inv ? ~m_q : m_q;
        add_cin = iter_inv;
      end
      CORR: begin
        // nm_q holds -|divisor| + off_q from the first step, so the negated
        // corrected remainder -(A + |M|) = ~A + nm_q + ~off_q fits one pass.
        if (neg_rem_q) begin
          add_a   = ~a_q[31:0];
          add_b   = a_q[32] ? nm_q : '0;
          add_cin = a_q[32] ? ~off_q : 1'b1;
        end else begin
          add_a   = a_q[31:0];
          add_b   = m_neg_q ? ~m_q : m_q;
          add_cin = m_neg_q;
        end
      end
      SIGN: begin
        add_a   = ~quo_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    quo_d     = quo_q;
    m_d       = m_q;
    m_neg_d   = m_neg_q;
    nm_d      = nm_q;
    off_d     = off_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    q_d       = q_q;
    r_d       = r_q;
    dbz_out_d = dbz_out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_quo_d = dividend[31] ^ divisor[31];
          neg_rem_d = dividend[31];
          quo_d     = dividend[31] ? add_sum : dividend;
          m_d       = divisor;
          m_neg_d   = divisor[31];
          a_d       = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            dbz_d     = 1'b1;
            neg_rem_d = 1'b0;
            a_d       = {1'b0, dividend};
            state_d   = SIGN;
          end else begin
            dbz_d   = 1'b0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        a_d   = {iter_a32, add_sum};
        quo_d = {quo_q[30:0], ~iter_a32};
        if (cnt_q == '0) begin
          nm_d  = add_sum;
          off_d = quo_q[31];
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) state_d = CORR;
      end
      CORR: begin
        if (neg_rem_q || a_q[32]) a_d = {1'b0, add_sum};
        state_d = SIGN;
      end
      SIGN: begin
        q_d       = dbz_q ? DIV_BY_ZERO_Q : (neg_quo_q ? add_sum : quo_q);
        r_d       = a_q[31:0];
        dbz_out_d = dbz_q;
        done_d    = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      quo_q     <= '0;
      m_q       <= '0;
      m_neg_q   <= 1'b0;
      nm_q      <= '0;
      off_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      quo_q     <= quo_d;
      m_q       <= m_d;
      m_neg_q   <= m_neg_d;
      nm_q      <= nm_d;
      off_q     <= off_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_div_32.sv
// Directed bench for div_32: signs, overflow, divide-by-zero, ignored start, back-to-back, clr abort.
module tb_div_32;
  import div_pkg::*;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_by_zero;
  state_t      dbg_state;

  int total;
  int bad;

  div_32 dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drivers: all driving and sampling happens 1 time unit after a rising edge
  task automatic do_start(input logic [31:0] dvd, input logic [31:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (q !== 32'h0) begin bad++; $display("FAIL reset_q got=%h exp=00000000", q); end
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_r got=%h exp=00000000", r); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    clr = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    bit seen;
    bit busy_low;
    do_start(32'd100, 32'd7);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_e0 got=%b exp=1", busy); end
    n = 0; seen = 1'b0; busy_low = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else if (busy !== 1'b1) busy_low = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
    total++; if (n != DIV_LATENCY) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", n, DIV_LATENCY); end
    total++; if (busy_low) begin bad++; $display("FAIL basic_busy_hold got=dropped exp=held"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL basic_q got=%h exp=%h", q, 32'd14); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL basic_r got=%h exp=%h", r, 32'd2); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL basic_q_hold got=%h exp=%h", q, 32'd14); end
  endtask

  task automatic test_signs();
    logic [31:0] tv_a [0:8];
    logic [31:0] tv_b [0:8];
    logic [31:0] tv_q [0:8];
    logic [31:0] tv_r [0:8];
    int n;
    bit seen;
    tv_a = '{32'hFFFF_FF9C, 32'd100,        32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
             32'd7,         32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    tv_b = '{32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE,
             32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    tv_q = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'h8000_0000, 32'd3,
             32'hFFFF_FFFD, 32'd1,         32'd0,         32'd0};
    tv_r = '{32'hFFFF_FFFE, 32'd2,         32'd0,         32'd0,         32'hFFFF_FFFF,
             32'd1,         32'd0,         32'h7FFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 9; i++) begin
      do_start(tv_a[i], tv_b[i]);
      wait_done(n, seen);
      total++; if (!seen || n != DIV_LATENCY) begin bad++; $display("FAIL signs_latency[%0d] got=%0d exp=%0d", i, n, DIV_LATENCY); end
      total++; if (q !== tv_q[i]) begin bad++; $display("FAIL signs_q[%0d] %h/%h got=%h exp=%h", i, tv_a[i], tv_b[i], q, tv_q[i]); end
      total++; if (r !== tv_r[i]) begin bad++; $display("FAIL signs_r[%0d] %h/%h got=%h exp=%h", i, tv_a[i], tv_b[i], r, tv_r[i]); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL signs_dbz[%0d] got=%b exp=0", i, div_by_zero); end
    end
  endtask

  task automatic test_div_zero();
    int n;
    bit seen;
    do_start(32'd5, 32'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL dbz_busy_e0 got=%b exp=1", busy); end
    wait_done(n, seen);
    total++; if (!seen || n != 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dbz_busy_e1 got=%b exp=0", busy); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    total++; if (q !== DIV_BY_ZERO_Q) begin bad++; $display("FAIL dbz_q got=%h exp=%h", q, DIV_BY_ZERO_Q); end
    total++; if (r !== 32'd5) begin bad++; $display("FAIL dbz_r got=%h exp=%h", r, 32'd5); end
    @(posedge clk); #1;
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_hold got=%b exp=1", div_by_zero); end
    do_start(32'hFFFF_FFFB, 32'd0);
    wait_done(n, seen);
    total++; if (r !== 32'hFFFF_FFFB) begin bad++; $display("FAIL dbz_neg_r got=%h exp=FFFFFFFB", r); end
    do_start(32'd9, 32'd3);
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_inflight got=%b exp=1", div_by_zero); end
    wait_done(n, seen);
    total++; if (!seen || n != DIV_LATENCY) begin bad++; $display("FAIL dbz_next_latency got=%0d exp=%0d", n, DIV_LATENCY); end
    total++; if (q !== 32'd3) begin bad++; $display("FAIL dbz_next_q got=%h exp=%h", q, 32'd3); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL dbz_next_r got=%h exp=%h", r, 32'd0); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_next_flag got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    do_start(32'd1000, 32'd10);
    repeat (9) begin @(posedge clk); #1; end
    dividend = 32'd50;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done(n, seen);
    total++; if (!seen || n != DIV_LATENCY - 10) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", n, DIV_LATENCY - 10); end
    total++; if (q !== 32'd100) begin bad++; $display("FAIL b2b_first_q got=%h exp=%h", q, 32'd100); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL b2b_first_r got=%h exp=%h", r, 32'd0); end
    do_start(32'd77, 32'd5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(n, seen);
    total++; if (!seen || n + 1 != DIV_LATENCY + 1) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", n + 1, DIV_LATENCY + 1); end
    total++; if (q !== 32'd15) begin bad++; $display("FAIL b2b_second_q got=%h exp=%h", q, 32'd15); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL b2b_second_r got=%h exp=%h", r, 32'd2); end
  endtask

  task automatic test_clr_mid();
    int n;
    bit seen;
    bit done_seen;
    do_start(32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", busy); end
    total++; if (q !== 32'h0) begin bad++; $display("FAIL clr_q got=%h exp=00000000", q); end
    total++; if (r !== 32'h0) begin bad++; $display("FAIL clr_r got=%h exp=00000000", r); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL clr_state got=%0d exp=%0d", dbg_state, IDLE); end
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen = 1'b1;
    end
    total++; if (done_seen) begin bad++; $display("FAIL clr_no_done got=done exp=none"); end
    do_start(32'd7, 32'd2);
    wait_done(n, seen);
    total++; if (!seen || n != DIV_LATENCY) begin bad++; $display("FAIL clr_next_latency got=%0d exp=%0d", n, DIV_LATENCY); end
    total++; if (q !== 32'd3) begin bad++; $display("FAIL clr_next_q got=%h exp=%h", q, 32'd3); end
    total++; if (r !== 32'd1) begin bad++; $display("FAIL clr_next_r got=%h exp=%h", r, 32'd1); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    clr      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_back_to_back();
    test_clr_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
